bit_serializer: RTL and testbench

- Upstream feeder for the serial-input Mealy sequence detector.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per bit period on a single serial line, which drives the detector's `in`.
- Provides a per-bit strobe and a frame-start marker so downstream stages can align to word boundaries.
- Programmable bit period, inter-word gap and bit order.

---
 rtl/bit_serializer_pkg.sv | 31 +++
 rtl/bit_serializer_tick_gen.sv | 41 ++++
 rtl/bit_serializer.sv | 128 ++++++++++++
 tb/tb_bit_serializer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/bit_serializer_pkg.sv
// Shared state encoding, default parameters and sizing helpers for bit_serializer.
// SERIALIZER_PARITY_EN appends an even-parity bit to every frame.
package ser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } ser_state_e;

    localparam int DEF_DATA_W    = 8;
    localparam int DEF_DIV       = 1;
    localparam int DEF_GAP       = 0;
    localparam int DEF_MSB_FIRST = 1;

`ifdef SERIALIZER_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    function automatic int frame_len(input int data_w);
        return data_w + PAR_BITS;
    endfunction

    // Width able to hold 0..max_val; never narrower than one bit.
    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/bit_serializer_tick_gen.sv
// Bit-period tick counter: first_tick_o/last_tick_o bracket each DIV-cycle bit.
// Zero latency from counter state; restarts at 0 on load or reset.
module bit_tick_gen
    import ser_pkg::*;
#(
    parameter int DIV = DEF_DIV
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic first_tick_o,
    output logic last_tick_o
);

    localparam int TW = cnt_w(DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

    logic [TW-1:0] tick_q, tick_d;

    assign first_tick_o = (tick_q == '0);
    assign last_tick_o  = (tick_q == TICK_LAST);

    always_comb begin
        tick_d = tick_q;
        if (load_i) begin
            tick_d = '0;
        end else if (en_i) begin
            tick_d = last_tick_o ? '0 : tick_q + TW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_d;
        end
    end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter feeding the sequence detector; bit 0 appears the cycle after the handshake.
// data_ready is high in IDLE, and on the final cycle of a frame when GAP==0; build option SERIALIZER_PARITY_EN.
module bit_serializer
    import ser_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DIV       = DEF_DIV,
    parameter int GAP       = DEF_GAP,
    parameter int MSB_FIRST = DEF_MSB_FIRST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    output logic              ser_out,
    output logic              bit_stb,
    output logic              frame_start,
    output logic              busy
);

    localparam int FL   = frame_len(DATA_W);
    localparam int BC_W = cnt_w(FL);
    localparam int GC_W = cnt_w(GAP * DIV);
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(FL - 1);
    localparam logic [GC_W-1:0] GAP_LAST = GC_W'((GAP * DIV > 0) ? GAP * DIV - 1 : 0);

    ser_state_e      state_q, state_d;
    logic [FL-1:0]   sh_q, sh_d;
    logic [BC_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [GC_W-1:0] gap_cnt_q, gap_cnt_d;
    logic            rdy_en_q;
    logic            first_tick, last_tick;
    logic            xfer, bit_done, frame_end;
    logic [FL-1:0]   load_word;

`ifdef SERIALIZER_PARITY_EN
    logic parity;
    assign parity    = ^data_in;
    assign load_word = (MSB_FIRST != 0) ? {data_in, parity} : {parity, data_in};
`else
    assign load_word = data_in;
`endif

    bit_tick_gen #(.DIV(DIV)) u_tick (
        .clk          (clk),
        .reset        (reset),
        .load_i       (xfer),
        .en_i         (state_q == ST_SHIFT),
        .first_tick_o (first_tick),
        .last_tick_o  (last_tick)
    );

    assign xfer      = data_valid && data_ready;
    assign bit_done  = (state_q == ST_SHIFT) && last_tick;
    assign frame_end = bit_done && (bit_cnt_q == BIT_LAST);

    // Bits shift out with zero fill, so the register is all-zero once a frame drains.
    assign ser_out = (MSB_FIRST != 0) ? sh_q[FL-1] : sh_q[0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (xfer) state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (frame_end) begin
                    if (GAP > 0)   state_d = ST_GAP;
                    else if (xfer) state_d = ST_SHIFT;
                    else           state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy        = (state_q != ST_IDLE);
        bit_stb     = (state_q == ST_SHIFT) && first_tick;
        frame_start = bit_stb && (bit_cnt_q == '0);
        data_ready  = rdy_en_q &&
                      ((state_q == ST_IDLE) || ((GAP == 0) && frame_end));
    end

    always_comb begin
        sh_d      = sh_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = '0;
        if (xfer) begin
            sh_d      = load_word;
            bit_cnt_d = '0;
        end else if (bit_done) begin
            sh_d      = (MSB_FIRST != 0) ? (sh_q << 1) : (sh_q >> 1);
            bit_cnt_d = frame_end ? '0 : bit_cnt_q + BC_W'(1);
        end
        if ((state_q == ST_GAP) && (gap_cnt_q != GAP_LAST)) begin
            gap_cnt_d = gap_cnt_q + GC_W'(1);
        end
    end

    // rdy_en_q holds data_ready low for the first cycle after reset releases.
    always_ff @(posedge clk) begin
        if (reset) begin
            sh_q      <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            rdy_en_q  <= 1'b0;
        end else begin
            sh_q      <= sh_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            rdy_en_q  <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: default config plus a DIV=3/GAP=2/LSB-first instance.
`timescale 1ns/1ps
module tb_bit_serializer;

`ifdef SERIALIZER_PARITY_EN
    localparam int FL = 9;
`else
    localparam int FL = 8;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready, ser_out, bit_stb, frame_start, busy;
    logic [7:0] data_in2 = 8'h00;
    logic       data_valid2 = 1'b0;
    logic       data_ready2, ser_out2, bit_stb2, frame_start2, busy2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bit_serializer u_dut (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .ser_out     (ser_out),
        .bit_stb     (bit_stb),
        .frame_start (frame_start),
        .busy        (busy)
    );

    bit_serializer #(.DATA_W(8), .DIV(3), .GAP(2), .MSB_FIRST(0)) u_dut2 (
        .clk         (clk),
        .reset       (reset),
        .data_in     (data_in2),
        .data_valid  (data_valid2),
        .data_ready  (data_ready2),
        .ser_out     (ser_out2),
        .bit_stb     (bit_stb2),
        .frame_start (frame_start2),
        .busy        (busy2)
    );

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (data_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (data_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_timeout got %b want 1", name, data_ready);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        checks++; if (ser_out !== 1'b0)     begin errors++; $display("FAIL reset ser_out got %b want 0", ser_out); end
        checks++; if (bit_stb !== 1'b0)     begin errors++; $display("FAIL reset bit_stb got %b want 0", bit_stb); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL reset frame_start got %b want 0", frame_start); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset busy got %b want 0", busy); end
        checks++; if (data_ready !== 1'b0)  begin errors++; $display("FAIL reset data_ready got %b want 0", data_ready); end
        reset = 1'b0;
        checks++; if (data_ready !== 1'b0)  begin errors++; $display("FAIL reset release_ready got %b want 0", data_ready); end
        @(negedge clk);
        checks++; if (data_ready !== 1'b1)  begin errors++; $display("FAIL reset ready_rise got %b want 1", data_ready); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL reset busy_after got %b want 0", busy); end
    endtask

    // exp_bits is the expected on-wire data sequence, first bit in [7].
    task automatic test_single(input logic [7:0] w, input logic [7:0] exp_bits, input logic exp_par);
        logic exp;
        wait_ready("single");
        data_in = w;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        data_in = 8'h00;
        for (int i = 0; i < FL; i++) begin
            exp = (i < 8) ? exp_bits[7-i] : exp_par;
            checks++; if (ser_out !== exp)              begin errors++; $display("FAIL single w=%h bit%0d ser_out got %b want %b", w, i, ser_out, exp); end
            checks++; if (frame_start !== (i == 0))     begin errors++; $display("FAIL single w=%h bit%0d frame_start got %b want %b", w, i, frame_start, (i == 0)); end
            checks++; if (bit_stb !== 1'b1)             begin errors++; $display("FAIL single w=%h bit%0d bit_stb got %b want 1", w, i, bit_stb); end
            checks++; if (data_ready !== (i == FL - 1)) begin errors++; $display("FAIL single w=%h bit%0d data_ready got %b want %b", w, i, data_ready, (i == FL - 1)); end
            checks++; if (busy !== 1'b1)                begin errors++; $display("FAIL single w=%h bit%0d busy got %b want 1", w, i, busy); end
            @(negedge clk);
        end
        checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL single w=%h end busy got %b want 0", w, busy); end
        checks++; if (ser_out !== 1'b0)    begin errors++; $display("FAIL single w=%h end ser_out got %b want 0", w, ser_out); end
        checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL single w=%h end data_ready got %b want 1", w, data_ready); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e1, e2;
        logic       exp;
        int         j;
        e1 = 8'b10110100;
        e2 = 8'b00001111;
        wait_ready("b2b");
        data_in = 8'hB4;
        data_valid = 1'b1;
        @(negedge clk);
        data_in = 8'h0F;
        for (int i = 0; i < 2 * FL; i++) begin
            j = i % FL;
            if (j < 8) exp = (i < FL) ? e1[7-j] : e2[7-j];
            else       exp = 1'b0;
            checks++; if (ser_out !== exp) begin errors++; $display("FAIL b2b bit%0d ser_out got %b want %b", i, ser_out, exp); end
            checks++; if (frame_start !== (i == 0 || i == FL)) begin errors++; $display("FAIL b2b bit%0d frame_start got %b want %b", i, frame_start, (i == 0 || i == FL)); end
            checks++; if (bit_stb !== 1'b1) begin errors++; $display("FAIL b2b bit%0d bit_stb got %b want 1", i, bit_stb); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b bit%0d busy got %b want 1", i, busy); end
            checks++; if (data_ready !== (i == FL - 1 || i == 2 * FL - 1)) begin errors++; $display("FAIL b2b bit%0d data_ready got %b want %b", i, data_ready, (i == FL - 1 || i == 2 * FL - 1)); end
            if (i == FL) data_valid = 1'b0;
            @(negedge clk);
        end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL b2b end busy got %b want 0", busy); end
        checks++; if (ser_out !== 1'b0) begin errors++; $display("FAIL b2b end ser_out got %b want 0", ser_out); end
        data_in = 8'h00;
    endtask

    task automatic test_div_gap();
        int   n;
        int   stb_cnt;
        logic exp;
        n = 0;
        while (data_ready2 !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++; if (data_ready2 !== 1'b1) begin errors++; $display("FAIL divgap ready_timeout got %b want 1", data_ready2); end
        data_in2 = 8'h01;
        data_valid2 = 1'b1;
        @(negedge clk);
        data_valid2 = 1'b0;
        data_in2 = 8'h00;
        stb_cnt = 0;
        for (int c = 0; c < FL * 3; c++) begin
            // Bit 0 is 1 (LSB of 0x01); the parity bit of 0x01 is also 1.
            exp = (c < 3) || (c >= 24);
            if (bit_stb2 === 1'b1) stb_cnt++;
            checks++; if (ser_out2 !== exp) begin errors++; $display("FAIL divgap cyc%0d ser_out got %b want %b", c, ser_out2, exp); end
            checks++; if (bit_stb2 !== (c % 3 == 0)) begin errors++; $display("FAIL divgap cyc%0d bit_stb got %b want %b", c, bit_stb2, (c % 3 == 0)); end
            checks++; if (frame_start2 !== (c == 0)) begin errors++; $display("FAIL divgap cyc%0d frame_start got %b want %b", c, frame_start2, (c == 0)); end
            checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL divgap cyc%0d busy got %b want 1", c, busy2); end
            checks++; if (data_ready2 !== 1'b0) begin errors++; $display("FAIL divgap cyc%0d data_ready got %b want 0", c, data_ready2); end
            @(negedge clk);
        end
        checks++; if (stb_cnt != FL) begin errors++; $display("FAIL divgap stb_count got %0d want %0d", stb_cnt, FL); end
        for (int g = 0; g < 6; g++) begin
            checks++; if (busy2 !== 1'b1)       begin errors++; $display("FAIL divgap gap%0d busy got %b want 1", g, busy2); end
            checks++; if (ser_out2 !== 1'b0)    begin errors++; $display("FAIL divgap gap%0d ser_out got %b want 0", g, ser_out2); end
            checks++; if (bit_stb2 !== 1'b0)    begin errors++; $display("FAIL divgap gap%0d bit_stb got %b want 0", g, bit_stb2); end
            checks++; if (data_ready2 !== 1'b0) begin errors++; $display("FAIL divgap gap%0d data_ready got %b want 0", g, data_ready2); end
            @(negedge clk);
        end
        checks++; if (busy2 !== 1'b0)       begin errors++; $display("FAIL divgap idle busy got %b want 0", busy2); end
        checks++; if (data_ready2 !== 1'b1) begin errors++; $display("FAIL divgap idle data_ready got %b want 1", data_ready2); end
    endtask

    task automatic test_reset_mid();
        wait_ready("rstmid");
        data_in = 8'hFF;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        data_in = 8'h00;
        repeat (4) @(negedge clk);
        checks++; if (ser_out !== 1'b1) begin errors++; $display("FAIL rstmid bit4 ser_out got %b want 1", ser_out); end
        checks++; if (busy !== 1'b1)    begin errors++; $display("FAIL rstmid bit4 busy got %b want 1", busy); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (ser_out !== 1'b0)     begin errors++; $display("FAIL rstmid ser_out got %b want 0", ser_out); end
        checks++; if (busy !== 1'b0)        begin errors++; $display("FAIL rstmid busy got %b want 0", busy); end
        checks++; if (bit_stb !== 1'b0)     begin errors++; $display("FAIL rstmid bit_stb got %b want 0", bit_stb); end
        checks++; if (frame_start !== 1'b0) begin errors++; $display("FAIL rstmid frame_start got %b want 0", frame_start); end
        checks++; if (data_ready !== 1'b0)  begin errors++; $display("FAIL rstmid data_ready got %b want 0", data_ready); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL rstmid ready_after got %b want 1", data_ready); end
        checks++; if (ser_out !== 1'b0)    begin errors++; $display("FAIL rstmid idle ser_out got %b want 0", ser_out); end
        test_single(8'h80, 8'b10000000, 1'b1);
    endtask

    initial begin
        test_reset();
        test_single(8'hB4, 8'b10110100, 1'b0);
        test_back_to_back();
        test_div_gap();
        test_reset_mid();
        test_single(8'hB5, 8'b10110101, 1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog sim_time exceeded limit");
        $fatal(1);
    end

endmodule
